// File: rtl/float2fixed_pkg.sv
// Shared widths and tag type for the float2fixed converter arbiter.
package float2fixed_pkg;
  localparam int FLOAT_W      = 16;
  localparam int FIXED_W      = 44;
  localparam int CONV_LAT_DEF = 2;
  localparam int IDX_W        = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } conv_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);
  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Wrap ptr+k back into 0..N_REQ-1; one subtract suffices since both terms are < N_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, ptr} + SW'(k);
        if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
        idx = sum[PTR_W-1:0];
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/float2fixed_arbiter.sv
// Shares one float2fixed converter among N_REQ requesters; a tag pipeline routes results back.
module float2fixed_arbiter
  import float2fixed_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CONV_LAT = CONV_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FLOAT_W-1:0] req_float,
  output logic [N_REQ-1:0]         req_ready,
  output logic [FLOAT_W-1:0]       conv_float,
  input  logic [FIXED_W-1:0]       conv_fixed,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [FIXED_W-1:0]       rsp_fixed,
  output logic                     busy
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              gnt_idx;
  logic [N_REQ-1:0]              grant;
  logic                          xfer;
  logic [N_REQ-1:0][FLOAT_W-1:0] req_vec;
  conv_tag_t                     tag_pipe [CONV_LAT:0];
  conv_tag_t                     out_tag;
  logic                          any_tag;

  assign req_vec = req_float;

  // Gating with reset_n keeps req_ready low while reset is asserted.
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (enable & reset_n),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gnt_idx = PTR_W'(i);
  end

  // tag_pipe[0] is the issue tag aligned with conv_float; tag_pipe[CONV_LAT] lines up with conv_fixed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      conv_float <= '0;
      for (int s = 0; s <= CONV_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      if (xfer) begin
        ptr               <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
        conv_float        <= req_vec[gnt_idx];
        tag_pipe[0].valid <= 1'b1;
        tag_pipe[0].idx   <= IDX_W'(gnt_idx);
      end else begin
        conv_float  <= '0;
        tag_pipe[0] <= '0;
      end
      for (int s = 1; s <= CONV_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign out_tag = tag_pipe[CONV_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_fixed <= '0;
    end else if (out_tag.valid) begin
      rsp_valid <= N_REQ'(1) << out_tag.idx;
      rsp_fixed <= conv_fixed;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int s = 0; s <= CONV_LAT; s++) any_tag = any_tag | tag_pipe[s].valid;
  end

  assign busy = any_tag | (|rsp_valid);
endmodule
